// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word reads to a synchronous ROM from a
// local PC and buffers returned words in a small FIFO feeding decode (valid/ready).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImEn,
  output logic [31:0] ImAddr,
  input  logic [31:0] ImData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPC
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);

  // Handshake: a word moves to decode on any cycle where OutValid && OutReady are
  // both high; OutInstr/OutPC hold while OutValid && !OutReady, and only Reset or
  // Redirect may drop OutValid.

  logic [31:0]   fpc;
  logic [31:0]   pend_pc;
  logic          pending;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          issue;
  logic          push;
  logic          pop;
  logic [AW+1:0] credit_used;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  always_comb begin
    // Credit ignores a same-cycle pop so the FIFO can never overflow.
    credit_used = {1'b0, count} + {{(AW + 1){1'b0}}, pending};
    issue       = !Reset && !Redirect && (credit_used < DEPTH_W);
    push        = pending && !Redirect;
    pop         = (count != '0) && OutReady && !Redirect;
  end

  assign ImEn     = issue;
  assign ImAddr   = fpc;
  assign OutValid = (count != '0);
  assign OutInstr = OutValid ? mem_instr[rd_ptr] : 32'h0;
  assign OutPC    = OutValid ? mem_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fpc     <= RESET_PC;
      pending <= 1'b0;
      pend_pc <= 32'h0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (Redirect) begin
      // The word returning this cycle belongs to the old stream and is dropped.
      fpc     <= {RedirectPC[31:2], 2'b00};
      pending <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pend_pc <= fpc;
        fpc     <= fpc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      mem_pc[wr_ptr]    <= pend_pc;
      mem_instr[wr_ptr] <= ImData;
    end
  end

endmodule
